// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for a multicycle MIPS-subset datapath. The datapath has one
// shared memory port, one shared ALU and internal IR/A/B/ALUOut registers. This
// block walks the fetch/decode/execute/memory/write-back states and drives every
// datapath select and strobe. It also runs a watchdog on the memory handshake
// and counts retired instructions.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; while it is low every output is 0
//   opcode/funct instr[31:26] / instr[5:0], taken from the IR
//   mem_ready    memory completes the pending read/write this cycle
//   memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsrc,
//   alusrca, alusrcb, immext, alucontrol, regdst, memtoreg, regwrite
//                datapath controls (Moore; irwrite/pcwrite follow mem_ready in FETCH)
//   illegal      high while parked in ERROR
//   instret      retired-instruction counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       immext,
  output logic [2:0]       alucontrol,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Last wait count that may still be followed by another wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEXEC = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire_s;

  logic       memread_s, memwrite_s, iord_s, irwrite_s, pcwrite_s, pcwritecond_s;
  logic [1:0] pcsrc_s, alusrcb_s, immext_s;
  logic       alusrca_s, regdst_s, memtoreg_s, regwrite_s, illegal_s;
  logic [2:0] alucontrol_s;
  logic [3:0] rfn_s;

  // R-type funct decode: {valid, alucontrol}.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      6'b100000: r = {1'b1, 3'b010};  // add
      6'b100010: r = {1'b1, 3'b110};  // sub
      6'b100100: r = {1'b1, 3'b000};  // and
      6'b100101: r = {1'b1, 3'b001};  // or
      6'b101010: r = {1'b1, 3'b111};  // slt
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

  assign rfn_s = decode_funct(funct);

  // Next-state, watchdog and retire logic.
  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;     // any state change clears the watchdog
    retire_s  = 1'b0;
    instret_d = instret_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_RTYPE:                state_d = S_EXEC;
          OP_BEQ:                  state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMMEXEC;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (rfn_s[3]) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_IMMEXEC: state_d = S_IMMWB;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_ERROR;
    endcase
    if (retire_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // Sequencer state, watchdog counter and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode; only irwrite/pcwrite in FETCH look at mem_ready.
  always_comb begin
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    iord_s        = 1'b0;
    irwrite_s     = 1'b0;
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    pcsrc_s       = 2'b00;
    alusrca_s     = 1'b0;
    alusrcb_s     = 2'b00;
    immext_s      = 2'b00;
    alucontrol_s  = 3'b000;
    regdst_s      = 1'b0;
    memtoreg_s    = 1'b0;
    regwrite_s    = 1'b0;
    illegal_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_s    = 1'b1;
        alusrcb_s    = 2'b01;
        alucontrol_s = 3'b010;
        irwrite_s    = mem_ready;
        pcwrite_s    = mem_ready;
      end
      S_DECODE: begin
        alusrcb_s    = 2'b11;  // branch target precomputed into ALUOut
        alucontrol_s = 3'b010;
      end
      S_MEMADR: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = 3'b010;
      end
      S_MEMRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_EXEC: begin
        alusrca_s    = 1'b1;
        alucontrol_s = rfn_s[2:0];
      end
      S_ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_IMMEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        case (opcode)
          OP_ORI: begin
            immext_s     = 2'b01;
            alucontrol_s = 3'b001;
          end
          OP_LUI: begin
            // rs is $0 in lui encodings, so OR passes the shifted immediate.
            immext_s     = 2'b10;
            alucontrol_s = 3'b001;
          end
          default: begin
            immext_s     = 2'b00;
            alucontrol_s = 3'b010;
          end
        endcase
      end
      S_IMMWB: regwrite_s = 1'b1;
      S_BRANCH: begin
        alusrca_s     = 1'b1;
        alucontrol_s  = 3'b110;
        pcsrc_s       = 2'b01;
        pcwritecond_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      S_ERROR: illegal_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // Gate with reset so every strobe drops the instant reset is asserted.
  assign memread     = reset & memread_s;
  assign memwrite    = reset & memwrite_s;
  assign iord        = reset & iord_s;
  assign irwrite     = reset & irwrite_s;
  assign pcwrite     = reset & pcwrite_s;
  assign pcwritecond = reset & pcwritecond_s;
  assign pcsrc       = {2{reset}} & pcsrc_s;
  assign alusrca     = reset & alusrca_s;
  assign alusrcb     = {2{reset}} & alusrcb_s;
  assign immext      = {2{reset}} & immext_s;
  assign alucontrol  = {3{reset}} & alucontrol_s;
  assign regdst      = reset & regdst_s;
  assign memtoreg    = reset & memtoreg_s;
  assign regwrite    = reset & regwrite_s;
  assign illegal     = reset & illegal_s;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Each instruction is expanded into the list of cycles it should take. Every
// cycle carries the expected control word and says whether it is a memory
// handshake cycle. The bench steps through that list, draws mem_ready at random
// (or per a directed mode), and compares the full control word and instret.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int WL = 16;
  localparam int CW = 4;   // narrow counter so wrap-around is reached

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          mem_ready;
  logic          memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
  logic [1:0]    pcsrc, alusrcb, immext;
  logic          alusrca, regdst, memtoreg, regwrite, illegal;
  logic [2:0]    alucontrol;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .immext(immext), .alucontrol(alucontrol), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic       memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb, immext;
    logic [2:0] aluc;
    logic       regdst, memtoreg, regwrite, illegal;
  } ctl_t;

  typedef struct {
    ctl_t v;
    bit   is_mem;
    bit   is_fetch;
    bit   err_after;
  } step_t;

  ctl_t  got_s;
  assign got_s = {memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsrc,
                  alusrca, alusrcb, immext, alucontrol, regdst, memtoreg, regwrite, illegal};

  int    n_total = 0;
  int    n_bad   = 0;
  int    exp_instret = 0;
  int    wcnt = 0;
  bit    err_mode = 1'b0;
  int    rdy_mode = 0;
  int    rdy_hold = 0;
  int    rw_cnt = 0;
  step_t q[$];

  task automatic check_eq(input string tag, input logic [31:0] g, input logic [31:0] e);
    n_total++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, g, e, $time);
    end
  endtask

  task automatic push_step(input ctl_t v, input bit m, input bit f, input bit e);
    step_t s;
    s.v = v; s.is_mem = m; s.is_fetch = f; s.err_after = e;
    q.push_back(s);
  endtask

  function automatic bit pick_ready(input bit is_fetch);
    case (rdy_mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 9) < 7);
      2:       return is_fetch;            // memory stalls forever after fetch
      default: return (wcnt >= rdy_hold);  // ready after rdy_hold wait cycles
    endcase
  endfunction

  // Expand one instruction into expected cycles and execute it against the DUT.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    ctl_t  v;
    ctl_t  e;
    step_t st;
    bit    rdy;
    bit    legal_op;
    bit    fn_ok;
    logic [2:0] fa;
    q.delete();
    legal_op = op inside {LW, SW, RT, BEQ, JMP, ADDI, ORI, LUI};
    fn_ok = 1'b1;
    case (fn)
      F_ADD:   fa = 3'b010;
      F_SUB:   fa = 3'b110;
      F_AND:   fa = 3'b000;
      F_OR:    fa = 3'b001;
      F_SLT:   fa = 3'b111;
      default: begin fa = 3'b000; fn_ok = 1'b0; end
    endcase
    v = '0; v.memread = 1'b1; v.alusrcb = 2'b01; v.aluc = 3'b010;
    push_step(v, 1'b1, 1'b1, 1'b0);
    v = '0; v.alusrcb = 2'b11; v.aluc = 3'b010;
    push_step(v, 1'b0, 1'b0, !legal_op);
    if (op == LW || op == SW) begin
      v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluc = 3'b010;
      push_step(v, 1'b0, 1'b0, 1'b0);
    end
    case (op)
      LW: begin
        v = '0; v.memread = 1'b1; v.iord = 1'b1; push_step(v, 1'b1, 1'b0, 1'b0);
        v = '0; v.memtoreg = 1'b1; v.regwrite = 1'b1; push_step(v, 1'b0, 1'b0, 1'b0);
      end
      SW: begin
        v = '0; v.memwrite = 1'b1; v.iord = 1'b1; push_step(v, 1'b1, 1'b0, 1'b0);
      end
      RT: begin
        v = '0; v.alusrca = 1'b1; v.aluc = fa; push_step(v, 1'b0, 1'b0, !fn_ok);
        v = '0; v.regdst = 1'b1; v.regwrite = 1'b1;
        if (fn_ok) push_step(v, 1'b0, 1'b0, 1'b0);
      end
      BEQ: begin
        v = '0; v.alusrca = 1'b1; v.aluc = 3'b110; v.pcsrc = 2'b01; v.pcwritecond = 1'b1;
        push_step(v, 1'b0, 1'b0, 1'b0);
      end
      JMP: begin
        v = '0; v.pcsrc = 2'b10; v.pcwrite = 1'b1; push_step(v, 1'b0, 1'b0, 1'b0);
      end
      ADDI, ORI, LUI: begin
        v = '0; v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.immext = (op == ADDI) ? 2'b00 : ((op == ORI) ? 2'b01 : 2'b10);
        v.aluc   = (op == ADDI) ? 3'b010 : 3'b001;
        push_step(v, 1'b0, 1'b0, 1'b0);
        v = '0; v.regwrite = 1'b1; push_step(v, 1'b0, 1'b0, 1'b0);
      end
      default: ;
    endcase
    while (q.size() > 0 && !err_mode) begin
      st  = q[0];
      rdy = pick_ready(st.is_fetch);
      mem_ready = rdy;
      e = st.v;
      if (st.is_fetch && rdy) begin
        e.irwrite = 1'b1;
        e.pcwrite = 1'b1;
      end
      @(negedge clk);
      check_eq($sformatf("ctl_op%h_fn%h", op, fn), 32'(got_s), 32'(e));
      if (got_s.regwrite) rw_cnt++;
      @(posedge clk); #1;
      if (st.is_mem && !rdy) begin
        wcnt++;
        if (wcnt == WL) err_mode = 1'b1;
      end else begin
        wcnt = 0;
        void'(q.pop_front());
        if (st.is_fetch) begin
          opcode = op;
          funct  = fn;
        end
        if (st.err_after) err_mode = 1'b1;
        else if (q.size() == 0) exp_instret++;
      end
    end
    check_eq("instret", 32'(instret), 32'(exp_instret % (1 << CW)));
  endtask

  task automatic check_err(input int n);
    ctl_t v;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      v = '0; v.illegal = 1'b1;
      @(negedge clk);
      check_eq("error_state", 32'(got_s), 32'(v));
      @(posedge clk); #1;
    end
    check_eq("error_instret", 32'(instret), 32'(exp_instret % (1 << CW)));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(got_s), 32'd0);
    check_eq("reset_instret", 32'(instret), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_instret = 0;
    wcnt = 0;
    err_mode = 1'b0;
  endtask

  task automatic run_guarded(input logic [5:0] op, input logic [5:0] fn);
    run_instr(op, fn);
    if (err_mode) begin
      check_err(3);
      do_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout n_total=%0d", n_total);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] fns [5];
    ctl_t       v;
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{LW, SW, RT, RT, BEQ, JMP, ADDI, ORI, LUI};
    fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    reset = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
    @(posedge clk); #1;
    do_reset();

    // Zero-wait program: lw, sw, add, beq, j -> 19 cycles, 5 retired, 2 writes.
    rdy_mode = 0; rw_cnt = 0;
    run_guarded(LW, 6'd0);
    run_guarded(SW, 6'd0);
    run_guarded(RT, F_ADD);
    run_guarded(BEQ, 6'd0);
    run_guarded(JMP, 6'd0);
    check_eq("regwrite_cycles", 32'(rw_cnt), 32'd2);

    // Every R-type funct, then the immediate group.
    for (int i = 0; i < 5; i++) run_guarded(RT, fns[i]);
    run_guarded(ORI, 6'd0);
    run_guarded(LUI, 6'd0);
    run_guarded(ADDI, 6'd0);

    // Waits: 3 cycles, then WL-1 cycles (handshake wins on the limit cycle).
    rdy_mode = 3; rdy_hold = 3;
    run_guarded(LW, 6'd0);
    rdy_hold = WL - 1;
    run_guarded(LW, 6'd0);
    run_guarded(SW, 6'd0);

    // Stuck memory read -> watchdog ERROR.
    rdy_mode = 2;
    run_guarded(LW, 6'd0);

    // Illegal opcode and illegal funct.
    rdy_mode = 0;
    run_guarded(6'b111111, 6'd0);
    run_guarded(RT, 6'b000111);

    // Random program with random memory latency.
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 19) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 4)];
      run_guarded(op, fn);
    end

    // Reset asserted during a stalled store.
    rdy_mode = 0;
    run_guarded(RT, F_ADD);
    run_guarded(RT, F_OR);
    mem_ready = 1'b1;
    @(posedge clk); #1;            // FETCH -> DECODE
    opcode = SW; funct = 6'd0;
    @(posedge clk); #1;            // -> MEMADR
    @(posedge clk); #1;            // -> MEMWR
    mem_ready = 1'b0;
    #2;
    check_eq("memwr_before_reset", 32'(memwrite), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("memwr_async_drop", 32'(memwrite), 32'd0);
    check_eq("midreset_outputs", 32'(got_s), 32'd0);
    check_eq("midreset_instret", 32'(instret), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_instret = 0; err_mode = 1'b0;
    v = '0; v.memread = 1'b1; v.alusrcb = 2'b01; v.aluc = 3'b010;
    @(negedge clk);
    check_eq("fetch_after_reset", 32'(got_s), 32'(v));
    @(posedge clk); #1;
    wcnt = 1;                      // that FETCH cycle waited once
    run_guarded(RT, F_SLT);
    run_guarded(JMP, 6'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer for the multicycle variant of the MIPS-subset datapath: one shared memory port, one shared ALU, internal IR/A/B/ALUOut registers.
- Decodes the latched instruction, walks fetch/decode/execute/memory/write-back states and drives every datapath select and strobe.
- Handles a variable-latency memory handshake, enforces a wait watchdog and counts retired instructions.
- Sits between the datapath and the unified instruction/data memory.

Parameters:
- WAIT_LIMIT, 16: max cycles a memory state may wait for mem_ready before entering ERROR (1..255).
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from IR.
- funct  in  6  instr[5:0] from IR.
- mem_ready  in  1  memory completes read/write this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load IR.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load if ALU zero (datapath ANDs with zero).
- pcsrc  out  2  next-PC select: 00 ALU, 01 ALUOut (branch), 10 jump target.
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B select: 00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2.
- immext  out  2  imm extension: 00 sign, 01 zero, 10 upper (imm,16'b0).
- alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- memtoreg  out  1  write data: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write strobe.
- illegal  out  1  sticky error flag (ERROR state).
- instret  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset low: state=FETCH, wait counter=0, instret=0, illegal=0. All outputs forced 0 asynchronously while reset is low. First active edge after release starts FETCH.
- Outputs are Moore (decoded from state), except irwrite/pcwrite in FETCH, which equal mem_ready.
- Unlisted outputs are 0 in every state.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; irwrite=pcwrite=mem_ready. mem_ready=1 -> DECODE, else stay.
- DECODE: alusrca=0, alusrcb=11, immext=00, alucontrol=010 (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi / 001101 ori / 001111 lui -> IMMEXEC
  - 000010 j -> JUMP
  - any other -> ERROR
- MEMADR: alusrca=1, alusrcb=10, immext=00, alucontrol=010. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread=1, iord=1. mem_ready -> MEMWB, else stay.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: memwrite=1, iord=1. mem_ready -> FETCH (retires), else stay.
- EXEC: alusrca=1, alusrcb=00. alucontrol from funct: 100000 ADD 010, 100010 SUB 110, 100100 AND 000, 100101 OR 001, 101010 SLT 111. Other funct -> ERROR (no write). Valid funct -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- IMMEXEC: alusrca=1, alusrcb=10.
  - addi: immext=00, alucontrol=010.
  - ori: immext=01, alucontrol=001.
  - lui: immext=10, alucontrol=001 (A is $0 by encoding).
  - -> IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcwritecond=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- ERROR: illegal=1, all strobes 0, stays until reset.
- instret increments by 1 on the cycle leaving MEMWB, MEMWR (with mem_ready), ALUWB, IMMWB, BRANCH or JUMP. Wraps modulo 2^CNT_W.
- Watchdog: 8-bit wait counter cleared on entering FETCH/MEMRD/MEMWR and whenever mem_ready=1; increments each cycle those states wait. Reaching WAIT_LIMIT with mem_ready=0 -> ERROR. If mem_ready=1 on the limit cycle, the handshake wins.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - lw = 5
  - R-type, sw, addi, ori, lui = 4
  - beq, j = 3
- Reset asserted mid-instruction aborts immediately. No partial regwrite/memwrite after reset assertion.

Test Plan:
- mem_ready=1, IR sequence lw, sw, add, beq, j -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB, ... ; instret=5 after 19 cycles; regwrite high exactly 2 cycles total.
- add/sub/and/or/slt funct in EXEC -> alucontrol 010/110/000/001/111 respectively; ALUWB regdst=1, regwrite=1.
- ori then lui -> IMMEXEC immext=01, then 10, alucontrol=001; IMMWB regdst=0.
- FETCH with mem_ready low 3 cycles then high -> memread held 4 cycles, irwrite/pcwrite pulse only on 4th; watchdog clears.
- MEMRD with mem_ready stuck 0, WAIT_LIMIT=16 -> ERROR after 16 cycles, illegal=1, no regwrite; opcode 111111 -> ERROR from DECODE.
- Reset dropped low during MEMWR with memwrite=1 -> memwrite drops 0 asynchronously, instret=0; after release, memread=1 in FETCH next cycle.
